// File: rtl/sincronizador_codigo.sv
// Word-alignment and lock controller for the 6-bit line-code receive path.
// Hunts for a code boundary, confirms it, then delivers aligned words and counts errors.

module CombinatoriaCodigo (
   input  logic [5:0] palabra,
   output logic       valida
);

   // Membership test against the fixed set of legal 6-bit codes
   always_comb begin
      valida = 1'b0;
      case (palabra)
         6'd1,  6'd2,  6'd3,  6'd5,  6'd10, 6'd12, 6'd13, 6'd15,
         6'd20, 6'd21, 6'd22, 6'd23, 6'd25, 6'd30, 6'd31, 6'd32,
         6'd33, 6'd35, 6'd50, 6'd51, 6'd52, 6'd53: valida = 1'b1;
         default: valida = 1'b0;
      endcase
   end

endmodule

module sincronizador_codigo #(
   parameter int CONFIRMA = 4,
   parameter int PERDIDA  = 3
) (
   input  logic        Reloj,
   input  logic        Reset,
   input  logic        BitEntrada,
   input  logic        BitValido,
   input  logic        BorraErrores,
   output logic [5:0]  Palabra,
   output logic        PalabraValida,
   output logic        ErrorCodigo,
   output logic        Enganchado,
   output logic [1:0]  Estado,
   output logic [15:0] CuentaErrores
);

   localparam logic [1:0] BUSCA      = 2'd0;
   localparam logic [1:0] VERIFICA   = 2'd1;
   localparam logic [1:0] ENGANCHADO = 2'd2;
   localparam logic [3:0] CONFIRMA_W = 4'(CONFIRMA);
   localparam logic [3:0] PERDIDA_W  = 4'(PERDIDA);

   logic [5:0]  registro_r;
   logic [2:0]  llenado_r;
   logic [2:0]  fase_r;
   logic [3:0]  confirma_r;
   logic [3:0]  consecutivos_r;
   logic [1:0]  estado_r;
   logic [5:0]  palabra_r;
   logic        palabra_valida_r;
   logic        error_codigo_r;
   logic        enganchado_r;
   logic [15:0] cuenta_r;

   logic [5:0]  ventana_s;
   logic        valida_s;
   logic        lleno_s;
   logic        frontera_s;
   logic [1:0]  estado_s;
   logic [2:0]  fase_s;
   logic [3:0]  confirma_s;
   logic [3:0]  consecutivos_s;
   logic        entrega_s;
   logic        incrementa_s;

   // The decoder looks at the window as it will be after this bit is shifted in
   assign ventana_s  = {registro_r[4:0], BitEntrada};
   assign lleno_s    = (llenado_r == 3'd5);
   assign frontera_s = (fase_r == 3'd5);

   CombinatoriaCodigo u_decodificador (
      .palabra (ventana_s),
      .valida  (valida_s)
   );

   // Next-state decision for the hunt / verify / lock controller
   always_comb begin
      estado_s       = estado_r;
      fase_s         = fase_r;
      confirma_s     = confirma_r;
      consecutivos_s = consecutivos_r;
      entrega_s      = 1'b0;
      incrementa_s   = 1'b0;
      if (BitValido) begin
         fase_s = frontera_s ? 3'd0 : fase_r + 3'd1;
         case (estado_r)
            BUSCA: begin
               if (lleno_s && valida_s) begin
                  estado_s   = VERIFICA;
                  fase_s     = 3'd0;
                  confirma_s = 4'd1;
               end else begin
                  estado_s = BUSCA;
               end
            end
            VERIFICA: begin
               if (frontera_s) begin
                  if (valida_s) begin
                     confirma_s = confirma_r + 4'd1;
                     if (confirma_s == CONFIRMA_W) begin
                        estado_s       = ENGANCHADO;
                        consecutivos_s = 4'd0;
                     end else begin
                        estado_s = VERIFICA;
                     end
                  end else begin
                     estado_s = BUSCA;
                  end
               end else begin
                  estado_s = VERIFICA;
               end
            end
            ENGANCHADO: begin
               if (frontera_s) begin
                  entrega_s = 1'b1;
                  if (!valida_s) begin
                     incrementa_s   = 1'b1;
                     consecutivos_s = consecutivos_r + 4'd1;
                     if (consecutivos_s == PERDIDA_W) begin
                        estado_s = BUSCA;
                     end else begin
                        estado_s = ENGANCHADO;
                     end
                  end else begin
                     consecutivos_s = 4'd0;
                  end
               end else begin
                  estado_s = ENGANCHADO;
               end
            end
            default: estado_s = BUSCA;
         endcase
      end else begin
         estado_s = estado_r;
      end
   end

   // State, window and registered outputs; the fill counter survives loss of lock
   always_ff @(posedge Reloj) begin
      if (Reset) begin
         registro_r       <= 6'd0;
         llenado_r        <= 3'd0;
         fase_r           <= 3'd0;
         confirma_r       <= 4'd0;
         consecutivos_r   <= 4'd0;
         estado_r         <= BUSCA;
         palabra_r        <= 6'd0;
         palabra_valida_r <= 1'b0;
         error_codigo_r   <= 1'b0;
         enganchado_r     <= 1'b0;
         cuenta_r         <= 16'd0;
      end else begin
         estado_r         <= estado_s;
         fase_r           <= fase_s;
         confirma_r       <= confirma_s;
         consecutivos_r   <= consecutivos_s;
         enganchado_r     <= (estado_s == ENGANCHADO);
         palabra_valida_r <= entrega_s;
         error_codigo_r   <= entrega_s & ~valida_s;
         if (BitValido) begin
            registro_r <= ventana_s;
            llenado_r  <= lleno_s ? llenado_r : llenado_r + 3'd1;
         end else begin
            registro_r <= registro_r;
            llenado_r  <= llenado_r;
         end
         if (entrega_s) begin
            palabra_r <= ventana_s;
         end else begin
            palabra_r <= palabra_r;
         end
         if (BorraErrores) begin
            cuenta_r <= 16'd0;
         end else if (incrementa_s && (cuenta_r != 16'hFFFF)) begin
            cuenta_r <= cuenta_r + 16'd1;
         end else begin
            cuenta_r <= cuenta_r;
         end
      end
   end

   assign Palabra       = palabra_r;
   assign PalabraValida = palabra_valida_r;
   assign ErrorCodigo   = error_codigo_r;
   assign Enganchado    = enganchado_r;
   assign Estado        = estado_r;
   assign CuentaErrores = cuenta_r;

endmodule

// File: tb/tb_sincronizador_codigo.sv
// Randomized and directed bench for sincronizador_codigo with a queue-based scoreboard.
module tb_sincronizador_codigo;

   localparam int CONF = 4;
   localparam int PERD = 3;

   logic        Reloj;
   logic        Reset;
   logic        BitEntrada;
   logic        BitValido;
   logic        BorraErrores;
   logic [5:0]  Palabra;
   logic        PalabraValida;
   logic        ErrorCodigo;
   logic        Enganchado;
   logic [1:0]  Estado;
   logic [15:0] CuentaErrores;

   sincronizador_codigo #(.CONFIRMA(CONF), .PERDIDA(PERD)) dut (
      .Reloj         (Reloj),
      .Reset         (Reset),
      .BitEntrada    (BitEntrada),
      .BitValido     (BitValido),
      .BorraErrores  (BorraErrores),
      .Palabra       (Palabra),
      .PalabraValida (PalabraValida),
      .ErrorCodigo   (ErrorCodigo),
      .Enganchado    (Enganchado),
      .Estado        (Estado),
      .CuentaErrores (CuentaErrores)
   );

   initial Reloj = 1'b0;
   always #5 Reloj = ~Reloj;

   typedef struct {
      int pal;
      int err;
   } esperado_t;

   esperado_t exp_q[$];
   int codigos[22] = '{1, 2, 3, 5, 10, 12, 13, 15, 20, 21, 22, 23, 25, 30, 31, 32, 33, 35, 50, 51, 52, 53};

   int n_checks = 0;
   int n_errors = 0;

   // reference model: last six bits as a number, bits since reset, bits since alignment
   int m_win = 0, m_nbits = 0, m_fase = 0, m_estado = 0, m_conf = 0, m_consec = 0, m_err = 0, m_pal = 0;
   int lock_visto = 0, lock_bit = 0, pv_visto = 0, pv_bit = 0, n_err_pulsos = 0;

   function automatic int es_valido(input int w);
      for (int i = 0; i < 22; i++) if (codigos[i] == w) return 1;
      return 0;
   endfunction

   task automatic chk(input string nombre, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nombre, act, exp, $time);
      end
   endtask

   task automatic modelo(input bit b, input bit v, input bit clr, input bit rst);
      int ok;
      int frontera;
      esperado_t e;
      if (rst) begin
         m_win = 0; m_nbits = 0; m_fase = 0; m_estado = 0;
         m_conf = 0; m_consec = 0; m_err = 0; m_pal = 0;
         return;
      end
      if (v) begin
         frontera = (m_fase == 5) ? 1 : 0;
         m_win    = (m_win * 2 + int'(b)) % 64;
         m_nbits++;
         ok       = es_valido(m_win);
         m_fase   = (m_fase + 1) % 6;
         if (m_estado == 0) begin
            if (m_nbits >= 6 && ok == 1) begin
               m_estado = 1; m_fase = 0; m_conf = 1;
            end
         end else if (m_estado == 1) begin
            if (frontera == 1) begin
               if (ok == 1) begin
                  m_conf++;
                  if (m_conf == CONF) begin m_estado = 2; m_consec = 0; end
               end else begin
                  m_estado = 0;
               end
            end
         end else begin
            if (frontera == 1) begin
               m_pal = m_win;
               e.pal = m_win;
               e.err = 1 - ok;
               exp_q.push_back(e);
               if (ok == 0) begin
                  m_consec++;
                  if (m_err < 65535) m_err++;
                  if (m_consec == PERD) m_estado = 0;
               end else begin
                  m_consec = 0;
               end
            end
         end
      end
      if (clr) m_err = 0;
   endtask

   // one clock: drive, predict, check architectural outputs on the falling edge
   task automatic paso(input bit b, input bit v, input bit clr, input bit rst);
      BitEntrada = b; BitValido = v; BorraErrores = clr; Reset = rst;
      modelo(b, v, clr, rst);
      @(posedge Reloj);
      @(negedge Reloj);
      chk("Estado", int'(Estado), m_estado);
      chk("Enganchado", int'(Enganchado), (m_estado == 2) ? 1 : 0);
      chk("CuentaErrores", int'(CuentaErrores), m_err);
      chk("Palabra", int'(Palabra), m_pal);
      if (lock_visto == 0 && Enganchado == 1'b1) begin
         lock_visto = 1;
         lock_bit   = m_nbits;
      end
      #1;
   endtask

   task automatic enviar(input logic [5:0] w, input int huecos, input bit clr_ultimo);
      for (int i = 5; i >= 0; i--) begin
         for (int g = 0; g < huecos; g++) paso(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         paso(w[i], 1'b1, (i == 0) ? clr_ultimo : 1'b0, 1'b0);
      end
   endtask

   task automatic reiniciar();
      paso(1'b0, 1'b0, 1'b0, 1'b1);
      lock_visto = 0; pv_visto = 0; n_err_pulsos = 0;
   endtask

   // scoreboard monitor
   always @(negedge Reloj) begin
      esperado_t e;
      if (PalabraValida) begin
         if (pv_visto == 0) begin pv_visto = 1; pv_bit = m_nbits; end
         if (ErrorCodigo) n_err_pulsos++;
         if (exp_q.size() == 0) begin
            chk("PalabraValida_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_Palabra", int'(Palabra), e.pal);
            chk("sb_ErrorCodigo", int'(ErrorCodigo), e.err);
         end
      end else begin
         chk("ErrorCodigo_idle", int'(ErrorCodigo), 0);
      end
   end

   initial begin
      logic [5:0] w31;
      logic [5:0] pal;
      logic [8:0] prefijo;
      int huecos;
      w31 = 6'd31;
      Reset = 1'b1; BitEntrada = 1'b0; BitValido = 1'b0; BorraErrores = 1'b0;
      paso(1'b0, 1'b0, 1'b0, 1'b1);

      // reset after garbage
      for (int i = 0; i < 40; i++) paso(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      reiniciar();
      chk("rst_Palabra", int'(Palabra), 0);
      chk("rst_PalabraValida", int'(PalabraValida), 0);
      chk("rst_Estado", int'(Estado), 0);
      chk("rst_CuentaErrores", int'(CuentaErrores), 0);

      // lock on repeated 31, no gaps
      for (int k = 0; k < 36; k++) begin
         paso(w31[5 - (k % 6)], 1'b1, 1'b0, 1'b0);
         if (k == 5) chk("verifica_bit6", int'(Estado), 1);
      end
      chk("lock_bit", lock_bit, 24);
      chk("first_pv_bit", pv_bit, 30);

      // loss of lock
      n_err_pulsos = 0;
      for (int j = 0; j < 3; j++) enviar(6'd0, 0, 1'b0);
      paso(1'b0, 1'b0, 1'b0, 1'b0);
      chk("loss_pulses", n_err_pulsos, 3);
      chk("loss_count", int'(CuentaErrores), 3);
      chk("loss_Enganchado", int'(Enganchado), 0);
      chk("loss_Estado", int'(Estado), 0);

      // saturation and clear priority
      for (int j = 0; j < 20 && m_estado != 2; j++) enviar(w31, 0, 1'b0);
      chk("relock", int'(Enganchado), 1);
      force dut.cuenta_r = 16'hFFFF;
      m_err = 65535;
      paso(1'b0, 1'b0, 1'b0, 1'b0);
      release dut.cuenta_r;
      enviar(6'd0, 0, 1'b0);
      paso(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_count", int'(CuentaErrores), 65535);
      enviar(6'd0, 0, 1'b1);
      chk("clear_wins", int'(CuentaErrores), 0);

      // misaligned first match, then true alignment
      reiniciar();
      prefijo = 9'b000011111;
      for (int k = 8; k >= 0; k--) begin
         paso(prefijo[k], 1'b1, 1'b0, 1'b0);
         if (k == 3) chk("false_verifica", int'(Estado), 1);
      end
      for (int k = 0; k < 3; k++) paso(w31[5 - k], 1'b1, 1'b0, 1'b0);
      chk("false_busca", int'(Estado), 0);
      for (int k = 3; k < 6; k++) paso(w31[5 - k], 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) enviar(w31, 0, 1'b0);
      chk("false_lock_bit", lock_bit, 33);

      // gaps between bits, same lock point in bits
      reiniciar();
      for (int j = 0; j < 6; j++) enviar(w31, $urandom_range(0, 5), 1'b0);
      chk("gap_lock_bit", lock_bit, 24);
      chk("gap_first_pv_bit", pv_bit, 30);
      for (int k = 0; k < 3; k++) paso(w31[5 - k], 1'b1, 1'b0, 1'b0);
      reiniciar();
      chk("midrst_Enganchado", int'(Enganchado), 0);
      chk("midrst_Palabra", int'(Palabra), 0);
      chk("midrst_PalabraValida", int'(PalabraValida), 0);

      // randomized word stream with slips, gaps and clears
      for (int j = 0; j < 400; j++) begin
         if ($urandom_range(0, 99) < 85) pal = 6'(codigos[$urandom_range(0, 21)]);
         else pal = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 99) < 4) paso(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
         huecos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
         enviar(pal, huecos, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      end
      paso(1'b0, 1'b0, 1'b0, 1'b0);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
